// File: rtl/wavelet_sum_serializer.sv
// Snapshots the wavelet filter-bank sums and streams them out as strobed words.
// Optional trailing XOR checksum word: define SERIALIZER_CHECKSUM_EN.
module wavelet_sum_serializer #(
  parameter int         TOTAL_FILTERS = 3,
  parameter int         SUM_WIDTH     = 32,
  parameter int         BITS_PER_ELEM = 8,
  parameter int         STROBE_HALF   = 2,
  parameter logic [7:0] SYNC_WORD     = 8'hA5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [TOTAL_FILTERS*SUM_WIDTH-1:0] i_sums,
  input  logic                               i_sums_valid,
  output logic [BITS_PER_ELEM-1:0]           o_value,
  output logic                               o_data_clk,
  output logic                               o_busy,
  output logic                               o_overrun
);

  localparam int WPS  = SUM_WIDTH / BITS_PER_ELEM;
  localparam int NPAY = TOTAL_FILTERS * WPS;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int NWORDS = NPAY + 2;
`else
  localparam int NWORDS = NPAY + 1;
`endif
  localparam int IW    = $clog2(NWORDS + 1);
  localparam int NSLOT = 1 << IW;
  localparam int PW    = (STROBE_HALF > 1) ? $clog2(STROBE_HALF) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [PW-1:0]                      r_phase;
  logic [PW-1:0]                      w_phase_nxt;
  logic [IW-1:0]                      r_idx;
  logic [IW-1:0]                      w_idx_nxt;
  logic [IW-1:0]                      w_nidx;
  logic [BITS_PER_ELEM-1:0]           r_value;
  logic [BITS_PER_ELEM-1:0]           w_value_nxt;
  logic [TOTAL_FILTERS*SUM_WIDTH-1:0] r_shadow;
  logic                               r_overrun;
  logic                               w_cap;
  logic                               w_ph_last;
  logic                               w_idx_last;
  logic [BITS_PER_ELEM-1:0]           w_words [NSLOT];
`ifdef SERIALIZER_CHECKSUM_EN
  logic [BITS_PER_ELEM-1:0]           w_csum;
`endif

  assign w_ph_last  = (r_phase == PW'(STROBE_HALF - 1));
  assign w_idx_last = (r_idx == IW'(NWORDS - 1));
  assign w_nidx     = r_idx + IW'(1);

  // Frame word table from the shadow: sync, sums MSW first, optional checksum
  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      w_words[k] = '0;
    end
    w_words[0] = BITS_PER_ELEM'(SYNC_WORD);
`ifdef SERIALIZER_CHECKSUM_EN
    w_csum = '0;
`endif
    for (int p = 0; p < NPAY; p++) begin
      w_words[p+1] = r_shadow[(p / WPS) * SUM_WIDTH
                     + (WPS - 1 - (p % WPS)) * BITS_PER_ELEM
                     +: BITS_PER_ELEM];
`ifdef SERIALIZER_CHECKSUM_EN
      w_csum = w_csum ^ w_words[p+1];
`endif
    end
`ifdef SERIALIZER_CHECKSUM_EN
    w_words[NWORDS-1] = w_csum;
`endif
  end

  // Next-state, counter and value decisions for the strobe sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_idx_nxt   = r_idx;
    w_value_nxt = r_value;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_sums_valid) begin
          w_state_nxt = S_LOW;
          w_phase_nxt = '0;
          w_idx_nxt   = '0;
          w_value_nxt = BITS_PER_ELEM'(SYNC_WORD);
          w_cap       = 1'b1;
        end
      end
      S_LOW: begin
        if (w_ph_last) begin
          w_state_nxt = S_HIGH;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      S_HIGH: begin
        if (w_ph_last) begin
          w_phase_nxt = '0;
          if (w_idx_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_LOW;
            w_idx_nxt   = w_nidx;
            w_value_nxt = w_words[w_nidx];
          end
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, word register and snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_idx    <= '0;
      r_value  <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_idx   <= w_idx_nxt;
      r_value <= w_value_nxt;
      if (w_cap) begin
        r_shadow <= i_sums;
      end
    end
  end

  // Sticky flag for valid pulses dropped while a frame is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (i_sums_valid && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_value    = r_value;
  assign o_data_clk = (r_state == S_HIGH);
  assign o_busy     = (r_state != S_IDLE);
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_wavelet_sum_serializer.sv
// Directed bench for wavelet_sum_serializer (STROBE_HALF=2 and =1 instances).
// Tracks SERIALIZER_CHECKSUM_EN to expect the trailing checksum word.
module tb_wavelet_sum_serializer;

  typedef logic [7:0] bq_t[$];

`ifdef SERIALIZER_CHECKSUM_EN
  localparam int NW = 14;
`else
  localparam int NW = 13;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] sums;
  logic        valid;
  logic        valid1;
  logic [7:0]  value;
  logic [7:0]  value1;
  logic        dclk;
  logic        dclk1;
  logic        busy;
  logic        busy1;
  logic        ovr;
  logic        ovr1;

  int   n_chk = 0;
  int   n_err = 0;
  int   bcnt  = 0;
  int   bcnt1 = 0;
  int   terr  = 0;
  logic tog   = 1'b0;
  logic prev  = 1'b0;
  logic prev1 = 1'b0;
  bq_t  q;
  bq_t  q1;
  bq_t  e_def;
  bq_t  e_neg;

  always #5 clk = ~clk;

  wavelet_sum_serializer dut (
    .clk          (clk),
    .reset        (rst),
    .i_sums       (sums),
    .i_sums_valid (valid),
    .o_value      (value),
    .o_data_clk   (dclk),
    .o_busy       (busy),
    .o_overrun    (ovr)
  );

  wavelet_sum_serializer #(.STROBE_HALF(1)) dut1 (
    .clk          (clk),
    .reset        (rst),
    .i_sums       (sums),
    .i_sums_valid (valid1),
    .o_value      (value1),
    .o_data_clk   (dclk1),
    .o_busy       (busy1),
    .o_overrun    (ovr1)
  );

  always @(negedge clk) begin
    if (dclk && !prev) q.push_back(value);
    prev = dclk;
    if (busy) bcnt++;
  end

  always @(negedge clk) begin
    if (dclk1 && !prev1) q1.push_back(value1);
    prev1 = dclk1;
    if (busy1) begin
      bcnt1++;
      if (dclk1 !== tog) terr++;
      tog = ~tog;
    end else begin
      tog = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input bq_t got,
                             input bq_t exp);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic pulse();
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk("frame_end", busy, 0);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 400 && q.size() < n; i++) @(negedge clk);
    chk("reach_word", q.size() >= n, 1);
  endtask

  initial begin
    e_def = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
              8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    e_neg = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef SERIALIZER_CHECKSUM_EN
    e_def.push_back(8'hCC);
    e_neg.push_back(8'h00);
`endif
    rst    = 1'b1;
    valid  = 1'b0;
    valid1 = 1'b0;
    sums   = '0;
    repeat (2) @(negedge clk);
    chk("rst_value", value, 0);
    chk("rst_dclk", dclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Default frame and start-of-frame timing
    sums = {32'h99AABBCC, 32'h55667788, 32'h11223344};
    q.delete();
    bcnt = 0;
    pulse();
    chk("sof_busy", busy, 1);
    chk("sof_value", value, 8'hA5);
    chk("sof_dclk", dclk, 0);
    @(negedge clk);
    chk("sof_dclk_low2", dclk, 0);
    @(negedge clk);
    chk("sof_dclk_rise", dclk, 1);
    wait_done();
    chk("dflt_busy_len", bcnt, NW * 4);
    check_frame("dflt", q, e_def);
    chk("dflt_hold", value, 8'hCC);
    chk("dflt_ovr", ovr, 0);

    // Signed sum pattern
    sums = {64'h0, 32'hFFFFFFFF};
    q.delete();
    pulse();
    wait_done();
    check_frame("neg", q, e_neg);

    // Snapshot isolation and overrun
    sums = {32'h99AABBCC, 32'h55667788, 32'h11223344};
    q.delete();
    bcnt = 0;
    pulse();
    wait_words(5);
    sums = '1;
    pulse();
    chk("ovr_set", ovr, 1);
    wait_done();
    check_frame("snap", q, e_def);
    chk("snap_busy_len", bcnt, NW * 4);
    repeat (20) @(negedge clk);
    chk("snap_no_2nd", busy, 0);
    chk("snap_no_words", q.size(), NW);
    chk("ovr_sticky", ovr, 1);

    // Reset in the high phase of word 3
    sums = {32'h99AABBCC, 32'h55667788, 32'h11223344};
    q.delete();
    pulse();
    wait_words(4);
    chk("mid_in_high", dclk, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_value", value, 0);
    chk("mid_dclk", dclk, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ovr", ovr, 0);
    valid = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    chk("rst_wins", busy, 0);
    @(negedge clk);
    q.delete();
    pulse();
    wait_done();
    check_frame("post_rst", q, e_def);

    // Minimum strobe, back-to-back frames
    q1.delete();
    bcnt1  = 0;
    terr   = 0;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    for (int i = 0; i < 400 && busy1; i++) @(negedge clk);
    chk("min_f1_end", busy1, 0);
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    chk("min_f2_busy", busy1, 1);
    chk("min_f2_value", value1, 8'hA5);
    for (int i = 0; i < 400 && busy1; i++) @(negedge clk);
    chk("min_f2_end", busy1, 0);
    chk("min_busy_len", bcnt1, 2 * NW * 2);
    chk("min_words", q1.size(), 2 * NW);
    if (q1.size() >= NW) q1 = q1[NW:$];
    check_frame("min_f2", q1, e_def);
    chk("min_ovr", ovr1, 0);
    chk("min_toggle", terr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
